// File: rtl/apb_pkg.sv
// Shared constants and state encoding for the APB master bridge and its bench.
package apb_pkg;
  localparam int APB_AW   = 32;
  localparam int APB_DW   = 32;
  localparam int APB_SW   = 4;
  localparam int UART_IDX = 0;
  localparam int GPIO_IDX = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;
endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus bundle. The master view is the bridge;
// the slave view is whatever sits on the other side (sequencer + APB slaves).
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int NSLV = 2
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [APB_AW-1:0]    req_addr;
  logic [APB_DW-1:0]    req_wdata;
  logic [APB_SW-1:0]    req_strb;
  logic                 rsp_valid;
  logic [APB_DW-1:0]    rsp_rdata;
  logic                 rsp_err;
  logic [APB_AW-1:0]    padd;
  logic [APB_DW-1:0]    pdata;
  logic                 pwr;
  logic [APB_SW-1:0]    PSTRB;
  logic [NSLV-1:0]      psel;
  logic                 pen;
  logic [NSLV*APB_DW-1:0] prdata;
  logic [NSLV-1:0]      PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, prdata, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           padd, pdata, pwr, PSTRB, psel, pen
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, prdata, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           padd, pdata, pwr, PSTRB, psel, pen
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; expired is high once TIMEOUT-1
// stalled cycles have been counted. Saturates there until cleared.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: valid/ready commands in, SETUP->ACCESS transfers out, one
// response per command with decode-error and wait-state timeout reporting.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int NSLV    = 2,
  parameter int SEL_LSB = 12,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  apb_master_bridge_if.master bus
);
  // state  | meaning
  // IDLE   | waiting for a command, req_ready high
  // SETUP  | psel asserted, pen low, exactly one cycle
  // ACCESS | pen high, waiting for the selected pready or the timeout
  // RESP   | one-cycle rsp_valid pulse, then back to IDLE

  apb_state_e        state_q, state_d;
  logic [APB_AW-1:0] padd_q, padd_d;
  logic [APB_DW-1:0] pdata_q, pdata_d;
  logic              pwr_q, pwr_d;
  logic [APB_SW-1:0] pstrb_q, pstrb_d;
  logic [NSLV-1:0]   psel_q, psel_d;
  logic              pen_q, pen_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [SEL_W-1:0]  sel_idx;
  logic [NSLV-1:0]   psel_dec;
  logic              hit;
  logic              accept;
  logic              sel_ready;
  logic [APB_DW-1:0] sel_rdata;
  logic              tmr_clr, tmr_en, tmr_expired;

  assign bus.req_ready = (state_q == ST_IDLE) & rst;
  assign accept        = bus.req_valid & bus.req_ready;

  // Address decode; indices at or above NSLV leave psel_dec empty.
  always_comb begin
    sel_idx  = bus.req_addr[SEL_LSB +: SEL_W];
    psel_dec = '0;
    hit      = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (int'(sel_idx) == k) begin
        psel_dec[k] = 1'b1;
        hit         = 1'b1;
      end
    end
  end

  // Only the slave we are talking to is listened to.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (psel_q[k]) begin
        sel_ready = bus.PREADY[k];
        sel_rdata = bus.prdata[k*APB_DW +: APB_DW];
      end
    end
  end

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  assign tmr_clr = (state_q != ST_ACCESS);

  always_comb begin
    state_d     = state_q;
    padd_d      = padd_q;
    pdata_d     = pdata_q;
    pwr_d       = pwr_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    pen_d       = pen_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hit) begin
            padd_d  = bus.req_addr;
            pwr_d   = bus.req_write;
            pstrb_d = bus.req_write ? bus.req_strb : '0;
            if (bus.req_write) begin
              pdata_d = bus.req_wdata;
            end
            psel_d  = psel_dec;
            state_d = ST_SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        pen_d   = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready arriving on the timeout cycle still completes normally.
        if (sel_ready) begin
          psel_d      = '0;
          pen_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwr_q ? '0 : sel_rdata;
          state_d     = ST_RESP;
        end else if (tmr_expired) begin
          psel_d      = '0;
          pen_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      padd_q      <= '0;
      pdata_q     <= '0;
      pwr_q       <= 1'b0;
      pstrb_q     <= '0;
      psel_q      <= '0;
      pen_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      padd_q      <= padd_d;
      pdata_q     <= pdata_d;
      pwr_q       <= pwr_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      pen_q       <= pen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.padd      = padd_q;
  assign bus.pdata     = pdata_q;
  assign bus.pwr       = pwr_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.psel      = psel_q;
  assign bus.pen       = pen_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
